// File: rtl/param_op_pipe_if.sv
// Operand/result bundle for param_op_pipe: the master side drives the operand and
// opcode, the slave side returns the registered result, valid and overflow flag.
interface param_op_pipe_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic [2:0]       op;
    logic [WIDTH:0]   out;
    logic             out_valid;
    logic             ovf;

    modport master (
        output in, in_valid, op,
        input  out, out_valid, ovf
    );

    modport slave (
        input  in, in_valid, op,
        output out, out_valid, ovf
    );
endinterface

// File: rtl/param_op_pipe.sv
// Buffered operand pipeline with eight unbuffered opcodes and a registered result.
// Define PARAM_OP_PIPE_ACC_EN to enable saturating accumulate, running max and ovf.
module param_op_pipe #(
    parameter int             WIDTH    = 8,
    parameter int             IN_DEPTH = 1,
    parameter logic [WIDTH:0] ADD_K    = (WIDTH+1)'(2)
) (
    input logic              clock,
    input logic              reset_n,
    param_op_pipe_if.slave   bus
);

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_ADD  = 3'd1,
        OP_SHL  = 3'd2,
        OP_POP  = 3'd3,
        OP_SHR  = 3'd4,
        OP_ACC  = 3'd5,
        OP_MAX  = 3'd6,
        OP_CLR  = 3'd7
    } op_e;

    localparam logic [WIDTH:0] RES_MAX = {(WIDTH+1){1'b1}};

    logic [WIDTH-1:0]    buf_data_q [IN_DEPTH];
    logic [IN_DEPTH-1:0] buf_valid_q;

    logic [WIDTH-1:0] d;
    logic             dv;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   pop_cnt;
    op_e              op_cur;

    logic [WIDTH:0] out_q, out_d;
    logic           out_valid_q, out_valid_d;

    // Input buffer: the operand and its valid bit shift together.
    // NOTE: every stage is cleared by reset, so stale data can never surface
    // as a valid operand after reset is released.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < IN_DEPTH; i++) begin
                buf_data_q[i] <= '0;
            end
            buf_valid_q <= '0;
        end else begin
            buf_data_q[0]  <= bus.in;
            buf_valid_q[0] <= bus.in_valid;
            for (int i = 1; i < IN_DEPTH; i++) begin
                buf_data_q[i]  <= buf_data_q[i-1];
                buf_valid_q[i] <= buf_valid_q[i-1];
            end
        end
    end

    assign d      = buf_data_q[IN_DEPTH-1];
    assign dv     = buf_valid_q[IN_DEPTH-1];
    assign d_ext  = {1'b0, d};
    assign op_cur = op_e'(bus.op);

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + (WIDTH+1)'(d[i]);
        end
    end

`ifdef PARAM_OP_PIPE_ACC_EN
    logic               ovf_q, ovf_d;
    logic [WIDTH+1:0]   acc_sum;

    // One extra bit on the sum so saturation can be detected before truncation.
    assign acc_sum = {1'b0, out_q} + {2'b00, d};

    // NOTE: every output of this block gets a default first, so no path
    // through the case can infer a latch.
    always_comb begin
        out_d       = out_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (dv) begin
            out_valid_d = 1'b1;
            case (op_cur)
                OP_PASS: out_d = d_ext;
                OP_ADD:  out_d = d_ext + ADD_K;
                OP_SHL:  out_d = {d, 1'b0};
                OP_POP:  out_d = pop_cnt;
                OP_SHR:  out_d = {2'b00, d[WIDTH-1:1]};
                OP_ACC: begin
                    if (acc_sum > {1'b0, RES_MAX}) begin
                        out_d = RES_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        out_d = acc_sum[WIDTH:0];
                    end
                end
                OP_MAX:  out_d = (d_ext > out_q) ? d_ext : out_q;
                OP_CLR: begin
                    out_d = '0;
                    ovf_d = 1'b0;
                end
                default: out_d = d_ext;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (dv) begin
            out_valid_d = 1'b1;
            case (op_cur)
                OP_PASS: out_d = d_ext;
                OP_ADD:  out_d = d_ext + ADD_K;
                OP_SHL:  out_d = {d, 1'b0};
                OP_POP:  out_d = pop_cnt;
                OP_SHR:  out_d = {2'b00, d[WIDTH-1:1]};
                OP_ACC:  out_d = d_ext;
                OP_MAX:  out_d = d_ext;
                OP_CLR:  out_d = '0;
                default: out_d = d_ext;
            endcase
        end
    end

    assign bus.ovf = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_param_op_pipe.sv
// Scoreboard bench for param_op_pipe: directed vectors on a depth-1 and a depth-3
// instance; monitors pop expected results whenever out_valid is seen.
module tb_param_op_pipe;

    localparam int W = 8;

`ifdef PARAM_OP_PIPE_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    typedef struct packed {
        logic [W:0] out;
        logic       ovf;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    param_op_pipe_if #(.WIDTH(W)) bus_a ();
    param_op_pipe_if #(.WIDTH(W)) bus_b ();

    param_op_pipe #(.WIDTH(W), .IN_DEPTH(1), .ADD_K(9'd2)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    param_op_pipe #(.WIDTH(W), .IN_DEPTH(3), .ADD_K(9'd2)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (bus_a.out_valid === 1'b1) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_spurious: got out_valid=1 out=%0d, expected no result", bus_a.out);
            end else begin
                e = q_a.pop_front();
                check("a_out", 32'(bus_a.out), 32'(e.out));
                check("a_ovf", 32'(bus_a.ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (bus_b.out_valid === 1'b1) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_spurious: got out_valid=1 out=%0d, expected no result", bus_b.out);
            end else begin
                e = q_b.pop_front();
                check("b_out", 32'(bus_b.out), 32'(e.out));
                check("b_ovf", 32'(bus_b.ovf), 32'(e.ovf));
            end
        end
    end

    // Apply one vector to instance A for one edge; optionally queue its expected result.
    task automatic sa(input logic [W-1:0] din, input logic v, input logic [2:0] op,
                      input bit has_exp, input int e_out, input bit e_ovf);
        exp_t e;
        bus_a.in       = din;
        bus_a.in_valid = v;
        bus_a.op       = op;
        if (has_exp) begin
            e.out = e_out[W:0];
            e.ovf = e_ovf;
            q_a.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic sb(input logic [W-1:0] din, input logic v, input logic [2:0] op);
        bus_b.in       = din;
        bus_b.in_valid = v;
        bus_b.op       = op;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bus_a.in = '0; bus_a.in_valid = 1'b0; bus_a.op = '0;
        bus_b.in = '0; bus_b.in_valid = 1'b0; bus_b.op = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_out",       32'(bus_a.out), 0);
        check("rst_out_valid", 32'(bus_a.out_valid), 0);
        check("rst_ovf",       32'(bus_a.ovf), 0);
        check("rst_b_valid",   32'(bus_b.out_valid), 0);

        // First valid operand needs one buffer edge before it can be computed.
        reset_n = 1'b1;
        sa(8'd9, 1'b1, 3'd0, 0, 0, 0);
        @(negedge clock);
        check("lat_out",       32'(bus_a.out), 0);
        check("lat_out_valid", 32'(bus_a.out_valid), 0);

        sa(8'd9,   1'b1, 3'd0, 1, 9,  0);
        sa(8'd9,   1'b1, 3'd1, 1, 11, 0);
        sa(8'd9,   1'b1, 3'd2, 1, 18, 0);
        sa(8'd9,   1'b1, 3'd3, 1, 2,  0);
        sa(8'd9,   1'b1, 3'd4, 1, 4,  0);
        sa(8'd143, 1'b1, 3'd3, 1, 2,  0);
        sa(8'd143, 1'b1, 3'd3, 1, 5,  0);
        sa(8'd200, 1'b1, 3'd7, 1, 0,  0);
        sa(8'd200, 1'b1, 3'd5, 1, 200, 0);
        sa(8'd200, 1'b1, 3'd5, 1, ACC ? 400 : 200, 0);
        sa(8'd200, 1'b1, 3'd5, 1, ACC ? 511 : 200, ACC);
        sa(8'd200, 1'b1, 3'd5, 1, ACC ? 511 : 200, ACC);
        sa(8'd200, 1'b1, 3'd1, 1, 202, ACC);
        sa(8'd250, 1'b1, 3'd6, 1, ACC ? 202 : 200, ACC);
        sa(8'd7,   1'b1, 3'd6, 1, 250, ACC);
        sa(8'd7,   1'b0, 3'd5, 1, ACC ? 257 : 7, ACC);

        // Invalid operand: result and flag hold, clear opcode ignored.
        sa(8'd3, 1'b0, 3'd7, 0, 0, 0);
        @(negedge clock);
        check("hold_out",       32'(bus_a.out), ACC ? 257 : 7);
        check("hold_out_valid", 32'(bus_a.out_valid), 0);
        check("hold_ovf",       32'(bus_a.ovf), 32'(ACC));

        sa(8'd3, 1'b1, 3'd7, 0, 0, 0);
        sa(8'd3, 1'b1, 3'd7, 1, 0, 0);

        // Reset with a valid operand in flight discards it.
        reset_n = 1'b0;
        sa(8'd3, 1'b1, 3'd0, 0, 0, 0);
        @(negedge clock);
        check("mrst_out",       32'(bus_a.out), 0);
        check("mrst_out_valid", 32'(bus_a.out_valid), 0);
        check("mrst_ovf",       32'(bus_a.ovf), 0);
        reset_n = 1'b1;
        sa(8'd4, 1'b1, 3'd0, 0, 0, 0);
        @(negedge clock);
        check("mrst_first_edge_valid", 32'(bus_a.out_valid), 0);
        sa(8'd4, 1'b0, 3'd0, 1, 4, 0);
        sa(8'd0, 1'b0, 3'd0, 0, 0, 0);

        // Depth-3 instance: a single-cycle pulse emerges exactly once, on the fourth edge.
        e.out = 9'd5;
        e.ovf = 1'b0;
        q_b.push_back(e);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) sb(8'd5, 1'b1, 3'd0);
            else        sb(8'd0, 1'b0, 3'd0);
            @(negedge clock);
            check($sformatf("b_valid_edge%0d", i + 1), 32'(bus_b.out_valid), (i == 3) ? 1 : 0);
        end

        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_op_pipe.md
PARAM_OP_PIPE -- requirements
Module: param_op_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Parameter IN_DEPTH, default 1, number of input buffer stages; legal range 1..8.
REQ-003 Parameter ADD_K, default 2, constant for op 1, WIDTH+1 bits.
REQ-004 Port clock  input  1  single clock; all state SHALL change on posedge clock only.
REQ-005 Port reset_n  input  1  synchronous, active-low reset.
REQ-006 Port in  input  WIDTH  operand.
REQ-007 Port in_valid  input  1  qualifies in; travels with in through the buffer.
REQ-008 Port op  input  3  opcode; unbuffered.
REQ-009 Port out  output  WIDTH+1  registered result.
REQ-010 Port out_valid  output  1  out updated on the last edge.
REQ-011 Port ovf  output  1  sticky accumulate-saturation flag.

Function
REQ-012 in/in_valid SHALL pass through an IN_DEPTH-stage register chain; d/dv denote the last stage.
REQ-013 op SHALL be sampled on the same edge that computes out: no buffering.
REQ-014 On an edge with dv=1, out SHALL load f(op,d) and out_valid SHALL be 1.
REQ-015 On an edge with dv=0, out and ovf SHALL hold and out_valid SHALL be 0.
REQ-016 Latency: in applied before edge k SHALL appear on out after edge k+IN_DEPTH, using op present at that edge.
REQ-017 op 0 pass: out = zero-extended d.
REQ-018 op 1 add: out = d + ADD_K modulo 2^(WIDTH+1).
REQ-019 op 2 shl: out = d << 1; no bit lost.
REQ-020 op 3 popcount: out = number of 1 bits in d, zero-extended.
REQ-021 op 4 shr: out = d >> 1, zero fill.
REQ-022 op 5 accumulate: out = out + d, saturating at 2^(WIDTH+1)-1; ovf SHALL set on any edge where the unsaturated sum exceeds the maximum.
REQ-023 op 6 running max: out = max(out, zero-extended d), unsigned.
REQ-024 op 7 clear: out = 0 and ovf = 0; out_valid = 1.
REQ-025 ovf SHALL clear only on reset or op 7 with dv=1; other ops SHALL leave it unchanged.
REQ-026 Accumulate already at maximum: out SHALL stay at maximum and ovf SHALL be 1.
REQ-027 Opcode changes between edges SHALL take effect at the next computing edge with no extra delay.

Reset
REQ-028 With reset_n=0 at a posedge, all buffer stages and their valid bits, out, out_valid and ovf SHALL be 0 after that edge.
REQ-029 Reset mid-operation SHALL discard all in-flight data; the first valid result follows IN_DEPTH+1 edges after the first valid input post-reset.
REQ-030 Reset SHALL take priority over every op and in_valid.

Configuration
REQ-031 Macro PARAM_OP_PIPE_ACC_EN defined: ops 5 and 6 SHALL behave as REQ-022/REQ-023.
REQ-032 Macro undefined: ops 5 and 6 SHALL behave as op 0 pass.
REQ-033 Macro undefined: ovf SHALL be constant 0.
REQ-034 Macro undefined: op 7 SHALL still clear out.

Verification (WIDTH=8, IN_DEPTH=1, ADD_K=2 unless stated)
REQ-035 Reset; in=9, in_valid=1, op=0 -> after edge 1 out=0, out_valid=0; after edge 2 out=9, out_valid=1.
REQ-036 Hold in=9 and step op 1,2,3,4 on successive edges -> out 11, 18, 2, 4.
REQ-037 op=3, in changes 9->143 -> next edge out=2 (old d), following edge out=5.
REQ-038 Macro defined; op 7 then in=200 with op 5 for three edges -> out 200, 400, 511; ovf=1 on the third edge; op 7 -> out=0, ovf=0.
REQ-039 IN_DEPTH=3, single-cycle in_valid pulse with in=5, op=0 -> out_valid high exactly one cycle, 4 edges later, out=5.
REQ-040 Macro undefined; in=7, op=5 -> out=7, ovf=0; reset_n=0 mid-stream -> all outputs 0 next edge.
